// File: rtl/router_reg_param.sv
// ---------------------------------------------------------------------------
// router_reg_param
//
// Router input register stage. It sits between the router input FSM and
// the per-channel output FIFOs. It captures the packet header and forwards
// the header, payload and check bytes to the FIFOs. While the selected FIFO
// is full it holds one byte. It keeps a running packet check (XOR parity or
// modulo-2^DATA_W sum) and flags a mismatch against the check byte that
// ends each packet.
//
// Parameters:
//   DATA_W   - byte width; header = {length[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}
//   ADDR_W   - width of the header address field
//   NUM_CH   - number of valid channels; headers with addr >= NUM_CH are ignored
//   CHK_MODE - 0 = XOR parity, 1 = additive checksum (carries dropped)
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   pkt_valid       - source packet valid, low on the check byte
//   data_in         - input byte
//   fifo_full       - selected output FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                   - one-hot state indications from the input FSM
//   rst_int_reg     - FSM request to clear low_pkt_valid
//   parity_done     - external check byte captured
//   low_pkt_valid   - check byte seen while loading
//   err             - check mismatch, valid one cycle after parity_done rises
//   dout, dout_valid- byte to the FIFO and its write enable
//   len_err         - (optional) payload count differs from header length
//
// Optional feature, macro ROUTER_LEN_CHECK_EN: adds a payload byte counter
// compared against the header length field. It contributes to err and
// drives the extra len_err output.
// ---------------------------------------------------------------------------
module router_reg_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int NUM_CH   = 3,
    parameter int CHK_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
`ifdef ROUTER_LEN_CHECK_EN
    ,
    output logic              len_err
`endif
);

`ifdef ROUTER_LEN_CHECK_EN
    localparam int LEN_W = DATA_W - ADDR_W;
`endif

    // One step of the running packet check.
    function automatic logic [DATA_W-1:0] chk_acc(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
        if (CHK_MODE == 0) begin
            return acc ^ b;
        end else begin
            return acc + b;
        end
    endfunction

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] int_chk_q, int_chk_d;
    logic [DATA_W-1:0] ext_chk_q, ext_chk_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;
    logic              parity_done_q, parity_done_d;
    logic              parity_dly_q, parity_dly_d;
    logic              err_q, err_d;
`ifdef ROUTER_LEN_CHECK_EN
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              len_err_q, len_err_d;
    logic              len_bad;
`endif

    logic hdr_addr_ok;
    logic payload_acc;
    logic parity_rise;
    logic mismatch;

    always_comb begin
        hdr_d           = hdr_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        int_chk_d       = int_chk_q;
        ext_chk_d       = ext_chk_q;
        dout_d          = dout_q;
        dout_valid_d    = 1'b0;
        low_pkt_valid_d = low_pkt_valid_q;
        parity_done_d   = parity_done_q;
        parity_dly_d    = parity_done_q;
        err_d           = err_q;

        hdr_addr_ok = ({1'b0, data_in[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_CH));
        payload_acc = ld_state && pkt_valid && !full_state;
        parity_rise = parity_done_q && !parity_dly_q;

        if (detect_add && pkt_valid && hdr_addr_ok) begin
            hdr_d = data_in;
        end

        if (detect_add) begin
            int_chk_d = '0;
        end else if (lfd_state) begin
            int_chk_d = chk_acc(int_chk_q, hdr_q);
        end else if (payload_acc) begin
            int_chk_d = chk_acc(int_chk_q, data_in);
        end

        // The hold register keeps only the first byte that arrives while the
        // FIFO is full. hold_full blocks later overwrites until the byte
        // drains in laf_state.
        if (lfd_state) begin
            dout_d       = hdr_q;
            dout_valid_d = 1'b1;
        end else if (ld_state) begin
            if (!fifo_full) begin
                dout_d       = data_in;
                dout_valid_d = 1'b1;
            end else if (!hold_full_q) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end else if (laf_state) begin
            dout_d       = hold_q;
            dout_valid_d = 1'b1;
            hold_full_d  = 1'b0;
        end
        if (detect_add) begin
            hold_full_d = 1'b0;
        end

        if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end

        // When the check byte arrives against a full FIFO, it is taken from
        // the hold register once the FIFO drains in laf_state.
        if (ld_state && !fifo_full && !pkt_valid) begin
            ext_chk_d     = data_in;
            parity_done_d = 1'b1;
        end else if (laf_state && low_pkt_valid_q && !parity_done_q) begin
            ext_chk_d     = hold_q;
            parity_done_d = 1'b1;
        end else if (detect_add) begin
            ext_chk_d     = '0;
            parity_done_d = 1'b0;
        end

`ifdef ROUTER_LEN_CHECK_EN
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        len_bad   = (cnt_q != hdr_q[DATA_W-1:ADDR_W]);
        if (detect_add) begin
            cnt_d = '0;
        end else if (payload_acc) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
        if (detect_add) begin
            len_err_d = 1'b0;
        end else if (parity_rise) begin
            len_err_d = len_bad;
        end
        mismatch = (ext_chk_q != int_chk_q) || len_bad;
`else
        mismatch = (ext_chk_q != int_chk_q);
`endif

        // The compare waits one cycle after parity_done rises. By then the
        // external check byte is registered and int_chk holds the whole
        // packet.
        if (detect_add) begin
            err_d = 1'b0;
        end else if (parity_rise) begin
            err_d = mismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q           <= '0;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            int_chk_q       <= '0;
            ext_chk_q       <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            parity_done_q   <= 1'b0;
            parity_dly_q    <= 1'b0;
            err_q           <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
            cnt_q           <= '0;
            len_err_q       <= 1'b0;
`endif
        end else begin
            hdr_q           <= hdr_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            int_chk_q       <= int_chk_d;
            ext_chk_q       <= ext_chk_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            parity_done_q   <= parity_done_d;
            parity_dly_q    <= parity_dly_d;
            err_q           <= err_d;
`ifdef ROUTER_LEN_CHECK_EN
            cnt_q           <= cnt_d;
            len_err_q       <= len_err_d;
`endif
        end
    end

    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
`ifdef ROUTER_LEN_CHECK_EN
    assign len_err       = len_err_q;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// ---------------------------------------------------------------------------
// tb_router_reg_param
//
// Testbench for router_reg_param. Two instances share one stimulus stream:
// one uses XOR parity and the other uses the additive checksum. A driver
// plays the input-FSM role packet by packet. For each packet it queues the
// byte stream the FIFO should receive and the err/len_err outcome of each
// instance. A monitor pops and compares those whenever an instance presents
// a byte or raises parity_done.
// ---------------------------------------------------------------------------
module tb_router_reg_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NUM_CH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
    logic        laf_state, full_state, rst_int_reg;
    logic [7:0]  data_in;

    logic [7:0]  dout0, dout1;
    logic        dout_valid0, dout_valid1;
    logic        parity_done0, parity_done1;
    logic        low_pkt_valid0, low_pkt_valid1;
    logic        err0, err1;
    logic        len_err0, len_err1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_dout0[$];
    logic [7:0] exp_dout1[$];
    logic [1:0] exp_err0[$];
    logic [1:0] exp_err1[$];

    logic [7:0] pay[$];
    logic [7:0] model_hdr;
    int         force_full_idx;

    logic       pd_prev[2];
    logic       pend[2];
    logic [1:0] model_e[2];
    logic [7:0] model_dout[2];

    always #5 clk = ~clk;

    router_reg_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CHK_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .parity_done(parity_done0),
        .low_pkt_valid(low_pkt_valid0), .err(err0), .dout(dout0),
        .dout_valid(dout_valid0)
`ifdef ROUTER_LEN_CHECK_EN
        , .len_err(len_err0)
`endif
    );

    router_reg_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CHK_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .parity_done(parity_done1),
        .low_pkt_valid(low_pkt_valid1), .err(err1), .dout(dout1),
        .dout_valid(dout_valid1)
`ifdef ROUTER_LEN_CHECK_EN
        , .len_err(len_err1)
`endif
    );

`ifndef ROUTER_LEN_CHECK_EN
    assign len_err0 = 1'b0;
    assign len_err1 = 1'b0;
`endif

    // Records a comparison and prints a FAIL line when the values differ.
    task automatic cmp(input string name, input int d, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
        end
    endtask

    // Drives one FSM cycle. Inputs change on the falling edge.
    task automatic applyStimulus(input logic det, input logic lfd, input logic ld,
                                 input logic laf, input logic fs, input logic pv,
                                 input logic ff, input logic rint,
                                 input logic [7:0] din);
        @(negedge clk);
        rst         = 1'b0;
        detect_add  = det;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fs;
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = rint;
        data_in     = din;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst         = 1'b1;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        rst_int_reg = 1'b0;
        data_in     = 8'h00;
        model_hdr   = 8'h00;
    endtask

    task automatic pushByte(input logic [7:0] b);
        exp_dout0.push_back(b);
        exp_dout1.push_back(b);
    endtask

    // Packet-level reference check over header and payload.
    function automatic logic [7:0] ref_check(input int mode, input logic [7:0] h);
        int acc;
        acc = int'(h);
        foreach (pay[i]) begin
            if (mode == 0) acc = acc ^ int'(pay[i]);
            else           acc = (acc + int'(pay[i])) % 256;
        end
        return 8'(acc);
    endfunction

    // Loads one byte, optionally against a full FIFO. In that case the FSM
    // goes through FIFO_FULL and LOAD_AFTER_FULL. dbl adds a second full
    // load cycle whose byte must be ignored.
    task automatic sendByte(input logic [7:0] b, input logic pv, input logic full,
                            input logic dbl);
        int n;
        if (!full) begin
            applyStimulus(0, 0, 1, 0, 0, pv, 0, 0, b);
        end else begin
            applyStimulus(0, 0, 1, 0, 0, pv, 1, 0, b);
            if (dbl) applyStimulus(0, 0, 1, 0, 0, pv, 1, 0, ~b);
            n = $urandom_range(1, 2);
            repeat (n) applyStimulus(0, 0, 0, 0, 1, pv, 1, 0, 8'($urandom));
            applyStimulus(0, 0, 0, 1, 0, pv, 0, 0, 8'($urandom));
        end
    endtask

    // kind 0: full packet; 1: aborted after cut payload bytes; 2: reset after cut bytes.
    task automatic sendPacket(input logic [7:0] hdr, input logic [7:0] chk,
                              input int full_pct, input int kind, input int cut);
        logic c0, c1, lbad, full, dbl;
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, hdr);
        if (int'(hdr[1:0]) < NUM_CH) model_hdr = hdr;
        pushByte(model_hdr);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < pay.size(); i++) begin
            if (kind != 0 && i == cut) break;
            pushByte(pay[i]);
            full = (i == force_full_idx) || ($urandom_range(0, 99) < full_pct);
            sendByte(pay[i], 1'b1, full, 1'b0);
        end
        if (kind == 1) return;
        if (kind == 2) begin
            doReset();
            return;
        end
        c0 = (ref_check(0, model_hdr) != chk);
        c1 = (ref_check(1, model_hdr) != chk);
`ifdef ROUTER_LEN_CHECK_EN
        lbad = (pay.size() != int'(model_hdr[7:2]));
`else
        lbad = 1'b0;
`endif
        exp_err0.push_back({c0 || lbad, lbad});
        exp_err1.push_back({c1 || lbad, lbad});
        pushByte(chk);
        full = ($urandom_range(0, 99) < full_pct);
        dbl  = full && ($urandom_range(0, 1) == 1);
        sendByte(chk, 1'b0, full, dbl);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Header with an out-of-range address, followed by LOAD_FIRST_DATA. The
    // previously captured header must come out.
    task automatic sendInvalid(input logic [7:0] hdr);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, hdr);
        pushByte(model_hdr);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Scoreboard side for one instance. Bytes are popped on dout_valid, and
    // err/len_err are popped one cycle after parity_done rises.
    task automatic checkOutput(input int d, input logic [7:0] db, input logic dv,
                               input logic pd, input logic lpv, input logic er,
                               input logic le);
        logic [7:0] exp_b;
        logic [1:0] exp_e;
        int         qn;
        if (rst) begin
            cmp("reset_outputs", d, 16'({dv, pd, lpv, er, le, db}), 16'h0000);
            pd_prev[d]    = 1'b0;
            pend[d]       = 1'b0;
            model_e[d]    = 2'b00;
            model_dout[d] = 8'h00;
            return;
        end
        if (dv) begin
            qn = (d == 0) ? exp_dout0.size() : exp_dout1.size();
            checks++;
            if (qn == 0) begin
                errors++;
                $display("[TB] FAIL dout_unexpected dut%0d actual=%0h expected=none", d, db);
            end else begin
                if (d == 0) exp_b = exp_dout0.pop_front();
                else        exp_b = exp_dout1.pop_front();
                if (db !== exp_b) begin
                    errors++;
                    $display("[TB] FAIL dout dut%0d actual=%0h expected=%0h", d, db, exp_b);
                end
                model_dout[d] = exp_b;
            end
        end else begin
            cmp("dout_hold", d, 16'(db), 16'(model_dout[d]));
        end
        if (pend[d]) begin
            if (d == 0) exp_e = exp_err0.pop_front();
            else        exp_e = exp_err1.pop_front();
            cmp("err_len_err", d, 16'({er, le}), 16'(exp_e));
            model_e[d] = exp_e;
            pend[d]    = 1'b0;
        end else if (detect_add) begin
            cmp("err_clear", d, 16'({er, le, pd}), 16'h0000);
            model_e[d] = 2'b00;
        end else begin
            cmp("err_hold", d, 16'({er, le}), 16'(model_e[d]));
        end
        if (pd && !pd_prev[d]) begin
            qn = (d == 0) ? exp_err0.size() : exp_err1.size();
            if (qn == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL parity_unexpected dut%0d actual=1 expected=0", d);
            end else begin
                pend[d] = 1'b1;
            end
        end
        pd_prev[d] = pd;
        if (ld_state && !pkt_valid) begin
            cmp("low_pkt_valid_set", d, 16'(lpv), 16'h0001);
        end else if (rst_int_reg) begin
            cmp("low_pkt_valid_clr", d, 16'(lpv), 16'h0000);
        end
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput(0, dout0, dout_valid0, parity_done0, low_pkt_valid0, err0, len_err0);
        checkOutput(1, dout1, dout_valid1, parity_done1, low_pkt_valid1, err1, len_err1);
    end

    initial begin
        int         len, addr, r, kind;
        logic [7:0] hdr, chk;
        rst = 1'b1;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0;
        data_in = 8'h00;
        model_hdr = 8'h00;
        force_full_idx = -1;
        for (int d = 0; d < 2; d++) begin
            pd_prev[d] = 1'b0; pend[d] = 1'b0; model_e[d] = 2'b00; model_dout[d] = 8'h00;
        end
        repeat (3) @(negedge clk);

        pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        sendPacket(8'h16, 8'h17, 0, 0, 0);
        sendPacket(8'h16, 8'h18, 0, 0, 0);
        sendPacket(8'h16, 8'h25, 0, 0, 0);
        force_full_idx = 2;
        sendPacket(8'h16, 8'h17, 0, 0, 0);
        force_full_idx = -1;
        sendPacket(8'h16, 8'h17, 100, 0, 0);
        sendInvalid(8'h17);
        sendPacket(8'h16, 8'h17, 0, 2, 3);
        sendInvalid(8'h17);
        sendPacket(8'h16, 8'h17, 0, 1, 2);
        pay.delete();
        sendPacket(8'h01, 8'h01, 0, 0, 0);
        pay = {8'hFF, 8'hFF, 8'h80};
        sendPacket(8'h0C, 8'h8A, 0, 0, 0);
        pay = {8'h01, 8'h02, 8'h03, 8'h04};
        sendPacket(8'h16, 8'h12, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            len  = $urandom_range(0, 8);
            addr = $urandom_range(0, NUM_CH - 1);
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            hdr = {6'(len), 2'(addr)};
            if ($urandom_range(0, 7) == 0) hdr = {6'(len + 1), 2'(addr)};
            r = $urandom_range(0, 2);
            if (r == 0)      chk = ref_check(0, hdr);
            else if (r == 1) chk = ref_check(1, hdr);
            else             chk = 8'($urandom);
            r = $urandom_range(0, 19);
            kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            if ($urandom_range(0, 9) == 0) sendInvalid({6'($urandom), 2'b11});
            sendPacket(hdr, chk, 25, kind, $urandom_range(0, len));
        end

        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        cmp("dout_queue_drained", 0, 16'(exp_dout0.size()), 16'h0000);
        cmp("dout_queue_drained", 1, 16'(exp_dout1.size()), 16'h0000);
        cmp("err_queue_drained", 0, 16'(exp_err0.size()), 16'h0000);
        cmp("err_queue_drained", 1, 16'(exp_err1.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
- Parametrised next-generation router input register stage.
- Sits between the input FSM and the per-channel output FIFOs.
- Captures the header and forwards header, payload and parity bytes to the FIFOs.
- Holds one byte while the FIFOs are full, computes a running packet check (XOR parity or additive checksum) and flags a mismatch.
- Generalised over data width, channel count and check mode.

Parameters:
- DATA_W, 8, byte width of data_in/dout; header = {length[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}.
- ADDR_W, 2, width of the header address field.
- NUM_CH, 3, number of valid channels; a header with addr >= NUM_CH is ignored.
- CHK_MODE, 0, 0 = XOR parity, 1 = modulo-2^DATA_W sum checksum.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- pkt_valid  in  1  source packet-valid; deasserted on the check byte.
- data_in  in  DATA_W  input byte.
- fifo_full  in  1  selected output FIFO full.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM clears low_pkt_valid.
- parity_done  out  1  external check byte captured.
- low_pkt_valid  out  1  check byte seen while loading.
- err  out  1  check mismatch.
- dout  out  DATA_W  byte to FIFO.
- dout_valid  out  1  dout carries a new byte this cycle (FIFO write enable).

Behaviour:
- Reset: every output 0, header/hold/internal/external check registers 0. rst has priority over all other inputs.
- Header: capture data_in into hdr when detect_add && pkt_valid && data_in[ADDR_W-1:0] < NUM_CH.
- Internal check accumulation:
  - cleared on detect_add.
  - lfd_state: accumulate hdr.
  - ld_state && pkt_valid && !full_state: accumulate data_in.
  - Accumulate is XOR (CHK_MODE=0) or add with carry discarded (CHK_MODE=1).
- dout / dout_valid (registered, 1-cycle latency):
  - lfd_state: dout <= hdr, dout_valid 1.
  - ld_state && !fifo_full: dout <= data_in, dout_valid 1.
  - ld_state && fifo_full: hold <= data_in, dout unchanged, dout_valid 0.
  - laf_state: dout <= hold, dout_valid 1.
  - Otherwise dout holds and dout_valid = 0.
- low_pkt_valid:
  - set when ld_state && !pkt_valid.
  - cleared by rst_int_reg; a simultaneous set wins.
- External check and parity_done:
  - ext_chk <= data_in, parity_done <= 1 when (ld_state && !fifo_full && !pkt_valid), or (laf_state && low_pkt_valid && !parity_done) using the held byte.
  - parity_done cleared on detect_add.
- err:
  - registered one cycle after parity_done rises: err <= (ext_chk != int_chk).
  - Holds until detect_add.
- Boundaries:
  - fifo_full on the check byte: the byte goes to hold, then completes via laf_state.
  - Two consecutive fifo_full cycles keep the first held byte; the FSM guarantees at most one.
  - detect_add mid-packet aborts: clears checks and flags; the header is recaptured if its address is valid.
  - Zero-length packet: check byte follows the header directly.
  - Checksum wrap-around: carries are dropped.

Optional Feature:
- Macro: ROUTER_LEN_CHECK_EN.
- When defined:
  - A LEN_W = DATA_W-ADDR_W payload counter is cleared on detect_add and increments per accumulated payload byte.
  - At the parity_done rise, err also asserts if count != hdr length field.
  - Extra output len_err (1 bit) flags the length mismatch alone, with the same set/clear timing as err.
- When undefined: no counter, no len_err port; err reflects the check comparison only.

Test Plan:
- CHK_MODE=0: header 8'h16 (len 5, addr 2), payload 01,02,03,04,05, check byte 8'h17, no fifo_full -> dout sequence 16,01..05,17 with dout_valid; parity_done=1, err=0.
- Same packet with check byte 8'h18 -> err=1 one cycle after parity_done, cleared on the next detect_add.
- CHK_MODE=1: same header and payload, check byte 8'h25 -> err=0; check byte 8'h17 -> err=1.
- fifo_full during payload byte 03 in ld_state, then laf_state -> hold=03, dout_valid 0 for that cycle, then dout=03; final err=0.
- Header 8'h17 (addr 3, NUM_CH=3) -> hdr unchanged; rst asserted mid-payload -> all outputs 0 on the next edge.
- ROUTER_LEN_CHECK_EN defined, header 8'h16 with 4 payload bytes and a correct XOR check byte -> len_err=1, err=1.
